// File: rtl/mips32_pkg.sv
// -----------------------------------------------------------------------------
// mips32_pkg
//   Definitions shared by the MIPS32 pipeline and its unified-memory arbiter:
//     - memory geometry defaults (MEM_AW, MEM_DW)
//     - arbiter FSM state encoding (RUN, DRAIN, HALTED)
//     - read-response owner encoding (NONE, IF, DM)
//     - starvation counter width
//     - opcode and instruction-type constants used by the pipeline stages
// -----------------------------------------------------------------------------
package mips32_pkg;

    // Unified instruction/data memory: 1024 x 32, word addressed.
    localparam int MEM_AW = 10;
    localparam int MEM_DW = 32;

    // Arbiter FSM. Plain localparam encoding keeps the state vector
    // compatible with older tools that mishandle enums in ports/traces.
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ST_RUN    = 2'd0;
    localparam arb_state_t ST_DRAIN  = 2'd1;
    localparam arb_state_t ST_HALTED = 2'd2;

    // Which requester the read data coming back next cycle belongs to.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    // Starvation counter is 4 bits wide, so STARVE_MAX is limited to 1..15.
    localparam int STARVE_CW = 4;

    // Opcodes (instruction bits [31:26]).
    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    // Instruction classes carried down the pipeline.
    typedef enum logic [2:0] {
        TY_RR_ALU = 3'd0,
        TY_RM_ALU = 3'd1,
        TY_LOAD   = 3'd2,
        TY_STORE  = 3'd3,
        TY_BRANCH = 3'd4,
        TY_HALT   = 3'd5
    } instr_type_e;

    // True for the opcodes that reach the data port of the arbiter.
    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// -----------------------------------------------------------------------------
// mem_arb_starve_ctr
//   Saturating count of consecutive cycles a pending fetch has lost
//   arbitration, with a compare output that tells the arbiter to force the
//   fetch through. Only built when MEM_ARB_STARVE_GUARD_EN is defined; in the
//   default build the arbiter uses strict data priority and this file is empty.
//
//   Ports:
//     clk1        in   clock
//     rst         in   asynchronous active-high reset
//     if_req      in   fetch request pending
//     if_ack      in   fetch granted this cycle
//     starve_hit  out  count has reached STARVE_MAX
// -----------------------------------------------------------------------------
`ifdef MEM_ARB_STARVE_GUARD_EN
module mem_arb_starve_ctr
    import mips32_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic clk1,
    input  logic rst,
    input  logic if_req,
    input  logic if_ack,
    output logic starve_hit
);

    logic [STARVE_CW-1:0] starve_cnt;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values, independent of block ordering.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!if_req || if_ack) begin
            starve_cnt <= '0;
        end else if (starve_cnt != '1) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign starve_hit = (starve_cnt == STARVE_CW'(STARVE_MAX));

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the unified synchronous RAM (1-cycle read latency) between the
//   instruction-fetch port (IF) and the data port (LW/SW). One access per
//   cycle, data has priority, read data is steered back to its owner the
//   cycle after the grant, and HLT is sequenced as RUN -> DRAIN -> HALTED.
//
//   Optional feature: define MEM_ARB_STARVE_GUARD_EN to let a fetch that has
//   lost STARVE_MAX consecutive cycles override the data port. Without it the
//   data port always wins and a fetch may wait indefinitely.
//
//   Ports:
//     clk1, rst                       clock, async active-high reset
//     if_req/if_addr                  fetch request (held until if_ack)
//     if_ack                          fetch issued to memory this cycle
//     if_rvalid/if_rdata              fetch data, cycle after if_ack
//     dm_req/dm_we/dm_addr/dm_wdata   data request (held until dm_ack)
//     dm_ack                          data request issued this cycle
//     dm_rvalid/dm_rdata              load data, cycle after a load's dm_ack
//     halt_in                         HLT retired (level or pulse)
//     mem_en/mem_we/mem_addr/mem_wdata  memory command
//     mem_rdata                       memory read data
//     halted                          no further accesses will be issued
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mips32_pkg::*;
#(
    parameter int AW         = MEM_AW,
    parameter int DW         = MEM_DW,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk1,
    input  logic          rst,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,

    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ack,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,

    input  logic          halt_in,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          halted
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("mem_port_arbiter: STARVE_MAX must be in 1..15");
    end

    arb_state_t    state_q, state_d;
    owner_e        rsp_owner_q, rsp_owner_d;
    logic [DW-1:0] if_rdata_q, dm_rdata_q;
    logic          if_grant, dm_grant;
    logic          force_if;
    logic          drain_done;

    // -------------------------------------------------------------------------
    // Starvation override
    // -------------------------------------------------------------------------
`ifdef MEM_ARB_STARVE_GUARD_EN
    logic starve_hit;

    mem_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk1       (clk1),
        .rst        (rst),
        .if_req     (if_req),
        .if_ack     (if_grant),
        .starve_hit (starve_hit)
    );

    // Only meaningful in RUN: in DRAIN the fetch is never granted, and the
    // counter saturating there must not block the data port.
    assign force_if = starve_hit && (state_q == ST_RUN);
`else
    assign force_if = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Grant logic (combinational; acks and memory command in the grant cycle)
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        if_grant = 1'b0;
        dm_grant = 1'b0;
        // Grants are held off while reset is asserted so every output is 0.
        if (!rst) begin
            case (state_q)
                ST_RUN: begin
                    if (if_req && (force_if || !dm_req)) begin
                        if_grant = 1'b1;
                    end else if (dm_req) begin
                        dm_grant = 1'b1;
                    end
                end
                ST_DRAIN: dm_grant = dm_req;
                default:  ;
            endcase
        end
    end

    assign if_ack    = if_grant;
    assign dm_ack    = dm_grant;
    assign mem_en    = if_grant || dm_grant;
    assign mem_we    = dm_grant && dm_we;
    assign mem_addr  = if_grant ? if_addr : (dm_grant ? dm_addr : '0);
    assign mem_wdata = mem_we ? dm_wdata : '0;

    // -------------------------------------------------------------------------
    // Read-response steering
    // -------------------------------------------------------------------------
    always_comb begin
        rsp_owner_d = OWN_NONE;
        if (if_grant) begin
            rsp_owner_d = OWN_IF;
        end else if (dm_grant && !dm_we) begin
            rsp_owner_d = OWN_DM;
        end
    end

    assign if_rvalid = (rsp_owner_q == OWN_IF);
    assign dm_rvalid = (rsp_owner_q == OWN_DM);

    // The memory output only belongs to one port per cycle; the other port
    // keeps presenting the last word it received.
    assign if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
    assign dm_rdata = dm_rvalid ? mem_rdata : dm_rdata_q;

    // -------------------------------------------------------------------------
    // Halt sequencing
    // -------------------------------------------------------------------------
    // DRAIN is complete once no data request is waiting and no read is still
    // returning. Nothing can be issued in that cycle, so it already reports
    // halted.
    assign drain_done = (state_q == ST_DRAIN) && !dm_req && (rsp_owner_q == OWN_NONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (halt_in) state_d = ST_DRAIN;
            ST_DRAIN:  if (drain_done) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_HALTED;
        endcase
    end

    assign halted = (state_q == ST_HALTED) || drain_done;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            rsp_owner_q <= OWN_NONE;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            rsp_owner_q <= rsp_owner_d;
            if (if_rvalid) if_rdata_q <= mem_rdata;
            if (dm_rvalid) dm_rdata_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed, table-driven bench for mem_port_arbiter with a behavioural
//   1-cycle-latency RAM. Each table row is one clock cycle: inputs driven
//   after the falling edge, every output compared shortly afterwards.
//   Follows MEM_ARB_STARVE_GUARD_EN for the starvation expectations.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
    import mips32_pkg::*;

    localparam int AW = MEM_AW;
    localparam int DW = MEM_DW;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    localparam logic O = 1'b0;
    localparam logic I = 1'b1;

    localparam logic [DW-1:0] D5   = 32'h2800000A;
    localparam logic [DW-1:0] D6   = 32'h00221800;
    localparam logic [DW-1:0] D7   = 32'hCAFEF00D;
    localparam logic [DW-1:0] D3FF = 32'h12345678;
    localparam logic [DW-1:0] DB   = 32'hDEADBEEF;

    logic          clk1 = 1'b0;
    logic          rst;
    logic          if_req, if_ack, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we, dm_ack, dm_rvalid;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic          halt_in;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          halted;

    mem_port_arbiter #(
        .AW         (AW),
        .DW         (DW),
        .STARVE_MAX (3)
    ) dut (
        .clk1      (clk1),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ack    (dm_ack),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .halt_in   (halt_in),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .halted    (halted)
    );

    always #5 clk1 = ~clk1;

    // Behavioural synchronous RAM.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk1) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    typedef struct {
        logic          if_req;
        logic [AW-1:0] if_addr;
        logic          dm_req;
        logic          dm_we;
        logic [AW-1:0] dm_addr;
        logic [DW-1:0] dm_wdata;
        logic          halt;
        logic          e_if_ack;
        logic          e_dm_ack;
        logic          e_en;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic          e_if_rv;
        logic          e_dm_rv;
        logic [DW-1:0] e_if_rd;
        logic [DW-1:0] e_dm_rd;
        logic          e_halted;
    } vec_t;

    int    n_vec = 0;
    int    n_bad = 0;
    string tag;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s/%s: got %h, expected %h", tag, name, act, exp);
        end
    endtask

    task automatic check_outs(input vec_t t);
        check("if_ack",    32'(if_ack),    32'(t.e_if_ack));
        check("dm_ack",    32'(dm_ack),    32'(t.e_dm_ack));
        check("mem_en",    32'(mem_en),    32'(t.e_en));
        check("mem_we",    32'(mem_we),    32'(t.e_we));
        check("mem_addr",  32'(mem_addr),  32'(t.e_addr));
        check("mem_wdata", 32'(mem_wdata), 32'(t.e_wdata));
        check("if_rvalid", 32'(if_rvalid), 32'(t.e_if_rv));
        check("dm_rvalid", 32'(dm_rvalid), 32'(t.e_dm_rv));
        check("if_rdata",  32'(if_rdata),  32'(t.e_if_rd));
        check("dm_rdata",  32'(dm_rdata),  32'(t.e_dm_rd));
        check("halted",    32'(halted),    32'(t.e_halted));
    endtask

    task automatic drive(input vec_t t);
        if_req   = t.if_req;
        if_addr  = t.if_addr;
        dm_req   = t.dm_req;
        dm_we    = t.dm_we;
        dm_addr  = t.dm_addr;
        dm_wdata = t.dm_wdata;
        halt_in  = t.halt;
    endtask

    task automatic apply(input vec_t t);
        @(negedge clk1);
        drive(t);
        #1;
        check_outs(t);
    endtask

    // Cycle-by-cycle table: inputs | expected outputs in that same cycle.
    vec_t vecs [11];
    vec_t z;
    vec_t v;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[5]     = D5;
        mem[6]     = D6;
        mem[7]     = D7;
        mem[10'h3FF] = D3FF;

        z = '{default: '0};

        //           if_req addr   dm_req we  dm_addr   wdata  halt | ifack dmack en we addr     wdata  ifrv dmrv if_rd dm_rd halted
        vecs[0]  = '{I, 10'd5, O, O, 10'd0,   32'd0, O,   I, O, I, O, 10'd5,   32'd0, O, O, 32'd0, 32'd0, O};
        vecs[1]  = '{O, 10'd0, O, O, 10'd0,   32'd0, O,   O, O, O, O, 10'd0,   32'd0, I, O, D5,    32'd0, O};
        vecs[2]  = '{I, 10'd6, I, O, 10'h3FF, 32'd0, O,   O, I, I, O, 10'h3FF, 32'd0, O, O, D5,    32'd0, O};
        vecs[3]  = '{I, 10'd6, O, O, 10'd0,   32'd0, O,   I, O, I, O, 10'd6,   32'd0, O, I, D5,    D3FF,  O};
        vecs[4]  = '{O, 10'd0, O, O, 10'd0,   32'd0, O,   O, O, O, O, 10'd0,   32'd0, I, O, D6,    D3FF,  O};
        vecs[5]  = '{O, 10'd0, I, I, 10'd20,  DB,    O,   O, I, I, I, 10'd20,  DB,    O, O, D6,    D3FF,  O};
        vecs[6]  = '{O, 10'd0, I, O, 10'd20,  32'd0, O,   O, I, I, O, 10'd20,  32'd0, O, O, D6,    D3FF,  O};
        vecs[7]  = '{O, 10'd0, O, O, 10'd0,   32'd0, O,   O, O, O, O, 10'd0,   32'd0, O, I, D6,    DB,    O};
        vecs[8]  = '{I, 10'd5, O, O, 10'd0,   32'd0, O,   I, O, I, O, 10'd5,   32'd0, O, O, D6,    DB,    O};
        vecs[9]  = '{O, 10'd0, I, O, 10'd7,   32'd0, O,   O, I, I, O, 10'd7,   32'd0, I, O, D5,    DB,    O};
        vecs[10] = '{O, 10'd0, O, O, 10'd0,   32'd0, O,   O, O, O, O, 10'd0,   32'd0, O, I, D5,    D7,    O};

        // ---- Reset: outputs all 0 even with a fetch request present ----
        rst = 1'b1;
        drive(z);
        if_req  = 1'b1;
        if_addr = 10'd5;
        @(negedge clk1);
        #1;
        tag = "reset";
        check_outs(z);
        @(negedge clk1);
        rst = 1'b0;
        drive(z);

        // ---- Table: fetch, priority, store/load, back-to-back reads ----
        for (int i = 0; i < 11; i++) begin
            tag = $sformatf("vec%0d", i);
            apply(vecs[i]);
        end

        // ---- Continuous data traffic against a pending fetch ----
        begin
            logic prev_if;
            prev_if = 1'b0;
            for (int k = 0; k < 12; k++) begin
                tag = $sformatf("starve%0d", k);
                v = z;
                v.if_req  = 1'b1;
                v.if_addr = 10'd5;
                v.dm_req  = 1'b1;
                v.dm_addr = 10'd7;
                v.e_if_ack = GUARD && (k % 4 == 3);
                v.e_dm_ack = !v.e_if_ack;
                v.e_en     = 1'b1;
                v.e_addr   = v.e_if_ack ? 10'd5 : 10'd7;
                v.e_if_rv  = (k > 0) && prev_if;
                v.e_dm_rv  = (k > 0) && !prev_if;
                v.e_if_rd  = D5;
                v.e_dm_rd  = D7;
                apply(v);
                prev_if = v.e_if_ack;
            end
            tag = "starve_tail";
            v = z;
            v.e_if_rv = prev_if;
            v.e_dm_rv = !prev_if;
            v.e_if_rd = D5;
            v.e_dm_rd = D7;
            apply(v);
        end

        // ---- Reset the cycle after a read ack ----
        tag = "rst_mid_ack";
        v = z;
        v.if_req = 1'b1; v.if_addr = 10'd5;
        v.e_if_ack = 1'b1; v.e_en = 1'b1; v.e_addr = 10'd5;
        v.e_if_rd = D5; v.e_dm_rd = D7;
        apply(v);
        @(negedge clk1);
        rst = 1'b1;            // fetch request still present during reset
        #1;
        tag = "rst_mid_a";
        check_outs(z);
        @(negedge clk1);
        #1;
        tag = "rst_mid_b";
        check_outs(z);
        @(negedge clk1);
        rst = 1'b0;
        drive(z);
        #1;
        tag = "rst_release";
        check_outs(z);

        // ---- Halt together with a fetch: the fetch still goes ----
        tag = "hif0";
        v = z; v.if_req = 1'b1; v.if_addr = 10'd5; v.halt = 1'b1;
        v.e_if_ack = 1'b1; v.e_en = 1'b1; v.e_addr = 10'd5;
        apply(v);
        tag = "hif1";
        v = z; v.if_req = 1'b1; v.if_addr = 10'd6;
        v.e_if_rv = 1'b1; v.e_if_rd = D5;
        apply(v);
        tag = "hif2";
        v = z; v.if_req = 1'b1; v.if_addr = 10'd6;
        v.e_if_rd = D5; v.e_halted = 1'b1;
        apply(v);
        tag = "hif3";
        v = z; v.if_req = 1'b1; v.if_addr = 10'd6;
        v.dm_req = 1'b1; v.dm_we = 1'b1; v.dm_addr = 10'd9; v.dm_wdata = 32'h1;
        v.e_if_rd = D5; v.e_halted = 1'b1;
        apply(v);

        @(negedge clk1);
        rst = 1'b1;
        drive(z);
        @(negedge clk1);
        rst = 1'b0;

        // ---- Halt pulse with a load in flight and a fetch pending ----
        tag = "hlw0";
        v = z; v.if_req = 1'b1; v.if_addr = 10'd5;
        v.dm_req = 1'b1; v.dm_addr = 10'd7; v.halt = 1'b1;
        v.e_dm_ack = 1'b1; v.e_en = 1'b1; v.e_addr = 10'd7;
        apply(v);
        tag = "hlw1";
        v = z; v.if_req = 1'b1; v.if_addr = 10'd5;
        v.e_dm_rv = 1'b1; v.e_dm_rd = D7;
        apply(v);
        tag = "hlw2";
        v = z; v.if_req = 1'b1; v.if_addr = 10'd5;
        v.e_dm_rd = D7; v.e_halted = 1'b1;
        apply(v);
        for (int k = 0; k < 3; k++) begin
            tag = $sformatf("hlw_ignore%0d", k);
            v = z; v.if_req = 1'b1; v.if_addr = 10'd5;
            v.dm_req = 1'b1; v.dm_addr = 10'd20; v.halt = 1'b1;
            v.e_dm_rd = D7; v.e_halted = 1'b1;
            apply(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
